// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - arbitrates IC fetches and LSB accesses onto the single memory controller port
module mem_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              lsb_req_valid,
  input  logic              lsb_req_is_write,
  input  logic [ADDR_W-1:0] lsb_req_addr,
  input  logic [2:0]        lsb_req_len,
  input  logic [DATA_W-1:0] lsb_req_wdata,
  output logic              lsb_resp_valid,
  output logic [DATA_W-1:0] lsb_resp_data,
  output logic              mc_req_valid,
  output logic              mc_req_is_write,
  output logic [ADDR_W-1:0] mc_req_addr,
  output logic [2:0]        mc_req_len,
  output logic [DATA_W-1:0] mc_req_wdata,
  input  logic              mc_req_ready,
  input  logic              mc_resp_valid,
  input  logic [DATA_W-1:0] mc_resp_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_LSB} owner_t;

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_cnt_nxt;
  logic              r_mc_req_valid, w_mc_req_valid_nxt;
  logic              r_mc_req_is_write, w_mc_req_is_write_nxt;
  logic [ADDR_W-1:0] r_mc_req_addr, w_mc_req_addr_nxt;
  logic [2:0]        r_mc_req_len, w_mc_req_len_nxt;
  logic [DATA_W-1:0] r_mc_req_wdata, w_mc_req_wdata_nxt;
  logic              r_ic_resp_valid, w_ic_resp_valid_nxt;
  logic [DATA_W-1:0] r_ic_resp_data, w_ic_resp_data_nxt;
  logic              r_lsb_resp_valid, w_lsb_resp_valid_nxt;
  logic [DATA_W-1:0] r_lsb_resp_data, w_lsb_resp_data_nxt;

  logic              w_cancellable;
  logic              w_lsb_wins;
  logic              w_pulse_busy;
  logic [DATA_W-1:0] w_load_data;

  // Load data is zero-extended to the access length; the controller may leave stale upper bytes
  always_comb begin
    w_load_data = mc_resp_data;
    case (r_mc_req_len)
      3'd1:    w_load_data = DATA_W'(mc_resp_data[7:0]);
      3'd2:    w_load_data = DATA_W'(mc_resp_data[15:0]);
      default: w_load_data = mc_resp_data;
    endcase
  end

  // Next-state and next-output logic; every register holds unless rdy is high
  always_comb begin
    w_state_nxt           = r_state;
    w_owner_nxt           = r_owner;
    w_starve_cnt_nxt      = r_starve_cnt;
    w_mc_req_valid_nxt    = r_mc_req_valid;
    w_mc_req_is_write_nxt = r_mc_req_is_write;
    w_mc_req_addr_nxt     = r_mc_req_addr;
    w_mc_req_len_nxt      = r_mc_req_len;
    w_mc_req_wdata_nxt    = r_mc_req_wdata;
    w_ic_resp_valid_nxt   = r_ic_resp_valid;
    w_ic_resp_data_nxt    = r_ic_resp_data;
    w_lsb_resp_valid_nxt  = r_lsb_resp_valid;
    w_lsb_resp_data_nxt   = r_lsb_resp_data;

    // Stores must never be dropped by a flush; fetches and loads may be
    w_cancellable = (r_owner == OWN_IC) || ((r_owner == OWN_LSB) && !r_mc_req_is_write);
    w_lsb_wins    = lsb_req_valid && ((r_starve_cnt < LIMIT) || !ic_req_valid);
    // The owner still holds valid during its response pulse, so hold off arbitration one cycle
    w_pulse_busy  = r_ic_resp_valid || r_lsb_resp_valid;

    if (rdy) begin
      w_ic_resp_valid_nxt  = 1'b0;
      w_lsb_resp_valid_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          if (!clear && !w_pulse_busy) begin
            if (w_lsb_wins) begin
              w_owner_nxt           = OWN_LSB;
              w_mc_req_valid_nxt    = 1'b1;
              w_mc_req_is_write_nxt = lsb_req_is_write;
              w_mc_req_addr_nxt     = lsb_req_addr;
              w_mc_req_len_nxt      = lsb_req_len;
              w_mc_req_wdata_nxt    = lsb_req_wdata;
              w_state_nxt           = ISSUE;
              if (!ic_req_valid)
                w_starve_cnt_nxt = '0;
              else if (r_starve_cnt != LIMIT)
                w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
            end else if (ic_req_valid) begin
              w_owner_nxt           = OWN_IC;
              w_mc_req_valid_nxt    = 1'b1;
              w_mc_req_is_write_nxt = 1'b0;
              w_mc_req_addr_nxt     = ic_req_addr;
              w_mc_req_len_nxt      = 3'd4;
              w_mc_req_wdata_nxt    = '0;
              w_state_nxt           = ISSUE;
              w_starve_cnt_nxt      = '0;
            end
          end
        end
        ISSUE: begin
          if (mc_req_ready) begin
            // Once accepted the controller will respond, so a flush must wait it out
            w_mc_req_valid_nxt = 1'b0;
            w_state_nxt        = (clear && w_cancellable) ? DRAIN : WAIT;
          end else if (clear && w_cancellable) begin
            w_mc_req_valid_nxt = 1'b0;
            w_state_nxt        = IDLE;
            w_owner_nxt        = OWN_NONE;
          end
        end
        WAIT: begin
          if (clear && w_cancellable) begin
            if (mc_resp_valid) begin
              w_state_nxt = IDLE;
              w_owner_nxt = OWN_NONE;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else if (mc_resp_valid) begin
            w_state_nxt = IDLE;
            w_owner_nxt = OWN_NONE;
            if (r_owner == OWN_IC) begin
              w_ic_resp_valid_nxt = 1'b1;
              w_ic_resp_data_nxt  = mc_resp_data;
            end else begin
              w_lsb_resp_valid_nxt = 1'b1;
              w_lsb_resp_data_nxt  = r_mc_req_is_write ? '0 : w_load_data;
            end
          end
        end
        DRAIN: begin
          if (mc_resp_valid) begin
            w_state_nxt = IDLE;
            w_owner_nxt = OWN_NONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_owner_nxt = OWN_NONE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_owner           <= OWN_NONE;
      r_starve_cnt      <= '0;
      r_mc_req_valid    <= 1'b0;
      r_mc_req_is_write <= 1'b0;
      r_mc_req_addr     <= '0;
      r_mc_req_len      <= '0;
      r_mc_req_wdata    <= '0;
      r_ic_resp_valid   <= 1'b0;
      r_ic_resp_data    <= '0;
      r_lsb_resp_valid  <= 1'b0;
      r_lsb_resp_data   <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_owner           <= w_owner_nxt;
      r_starve_cnt      <= w_starve_cnt_nxt;
      r_mc_req_valid    <= w_mc_req_valid_nxt;
      r_mc_req_is_write <= w_mc_req_is_write_nxt;
      r_mc_req_addr     <= w_mc_req_addr_nxt;
      r_mc_req_len      <= w_mc_req_len_nxt;
      r_mc_req_wdata    <= w_mc_req_wdata_nxt;
      r_ic_resp_valid   <= w_ic_resp_valid_nxt;
      r_ic_resp_data    <= w_ic_resp_data_nxt;
      r_lsb_resp_valid  <= w_lsb_resp_valid_nxt;
      r_lsb_resp_data   <= w_lsb_resp_data_nxt;
    end
  end

  assign mc_req_valid    = r_mc_req_valid;
  assign mc_req_is_write = r_mc_req_is_write;
  assign mc_req_addr     = r_mc_req_addr;
  assign mc_req_len      = r_mc_req_len;
  assign mc_req_wdata    = r_mc_req_wdata;
  assign ic_resp_valid   = r_ic_resp_valid;
  assign ic_resp_data    = r_ic_resp_data;
  assign lsb_resp_valid  = r_lsb_resp_valid;
  assign lsb_resp_data   = r_lsb_resp_data;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        lsb_req_valid, lsb_req_is_write;
  logic [31:0] lsb_req_addr;
  logic [2:0]  lsb_req_len;
  logic [31:0] lsb_req_wdata;
  logic        lsb_resp_valid;
  logic [31:0] lsb_resp_data;
  logic        mc_req_valid, mc_req_is_write;
  logic [31:0] mc_req_addr;
  logic [2:0]  mc_req_len;
  logic [31:0] mc_req_wdata;
  logic        mc_req_ready, mc_resp_valid;
  logic [31:0] mc_resp_data;

  int checks = 0;
  int errors = 0;
  int m_starve = 0;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .lsb_req_valid(lsb_req_valid), .lsb_req_is_write(lsb_req_is_write),
    .lsb_req_addr(lsb_req_addr), .lsb_req_len(lsb_req_len), .lsb_req_wdata(lsb_req_wdata),
    .lsb_resp_valid(lsb_resp_valid), .lsb_resp_data(lsb_resp_data),
    .mc_req_valid(mc_req_valid), .mc_req_is_write(mc_req_is_write),
    .mc_req_addr(mc_req_addr), .mc_req_len(mc_req_len), .mc_req_wdata(mc_req_wdata),
    .mc_req_ready(mc_req_ready), .mc_resp_valid(mc_resp_valid), .mc_resp_data(mc_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: LSB first unless it has already taken LIMIT grants in a row while IC waited
  task automatic expect_grant(output bit lsb);
    lsb = lsb_req_valid && (m_starve < LIMIT || !ic_req_valid);
    if (lsb && ic_req_valid) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
  endtask

  task automatic new_lsb(input bit we, input logic [31:0] addr, input logic [2:0] len, input logic [31:0] wd);
    lsb_req_valid = 1'b1; lsb_req_is_write = we; lsb_req_addr = addr; lsb_req_len = len; lsb_req_wdata = wd;
  endtask

  // Plays the controller for one complete transaction, starting from IDLE with requests already driven
  task automatic serve(input int rdly, input int wdly, input logic [31:0] rdata, input bit clr_store,
                       output bit was_lsb);
    int n;
    bit lsb;
    logic [31:0] ea, er;
    logic [2:0] el;
    logic ew;
    expect_grant(lsb);
    was_lsb = lsb;
    ea = lsb ? lsb_req_addr : ic_req_addr;
    el = lsb ? lsb_req_len : 3'd4;
    ew = lsb ? lsb_req_is_write : 1'b0;
    if (!lsb) er = rdata;
    else if (lsb_req_is_write) er = 32'h0;
    else if (lsb_req_len == 3'd1) er = rdata & 32'hFF;
    else if (lsb_req_len == 3'd2) er = rdata & 32'hFFFF;
    else er = rdata;
    n = 0;
    do begin tick; n++; end while (mc_req_valid !== 1'b1 && n < 20);
    chk("grant_latency", n, 1);
    chk("req_addr", mc_req_addr, ea);
    chk("req_len", {29'd0, mc_req_len}, {29'd0, el});
    chk("req_we", mc_req_is_write, ew);
    if (lsb) chk("req_wdata", mc_req_wdata, lsb_req_wdata);
    repeat (rdly) begin
      tick;
      chk("issue_hold_valid", mc_req_valid, 1);
      chk("issue_hold_addr", mc_req_addr, ea);
    end
    mc_req_ready = 1'b1;
    tick;
    mc_req_ready = 1'b0;
    chk("valid_drop_after_ready", mc_req_valid, 0);
    clear = clr_store && lsb && lsb_req_is_write;
    repeat (wdly) begin
      tick;
      clear = 1'b0;
      chk("no_early_pulse", {ic_resp_valid, lsb_resp_valid}, 0);
    end
    mc_resp_valid = 1'b1;
    mc_resp_data  = rdata;
    tick;
    clear = 1'b0;
    mc_resp_valid = 1'b0;
    mc_resp_data  = $urandom;
    chk("ic_pulse", ic_resp_valid, !lsb);
    chk("lsb_pulse", lsb_resp_valid, lsb);
    chk("resp_data", lsb ? lsb_resp_data : ic_resp_data, er);
    if (lsb) lsb_req_valid = 1'b0; else ic_req_valid = 1'b0;
    tick;
    chk("pulse_one_cycle", {ic_resp_valid, lsb_resp_valid}, 0);
  endtask

  initial begin
    bit w;
    int nl;
    logic [2:0] rl;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    lsb_req_valid = 1'b0; lsb_req_is_write = 1'b0; lsb_req_addr = '0; lsb_req_len = '0; lsb_req_wdata = '0;
    mc_req_ready = 1'b0; mc_resp_valid = 1'b0; mc_resp_data = '0;
    repeat (2) tick;
    chk("reset_valids", {mc_req_valid, mc_req_is_write, ic_resp_valid, lsb_resp_valid}, 0);
    chk("reset_addr", mc_req_addr, 0);
    chk("reset_len", {29'd0, mc_req_len}, 0);
    chk("reset_wdata", mc_req_wdata, 0);
    chk("reset_resp_data", ic_resp_data | lsb_resp_data, 0);
    rst = 1'b0;
    tick;

    // IC fetch alone
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
    serve(0, 2, 32'h00A0_0093, 1'b0, w);
    chk("ic_only_owner", w, 0);

    // Simultaneous IC and LSB load: LSB first, IC next
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_2000;
    new_lsb(1'b0, 32'h20, 3'd2, 32'hFFFF_FFFF);
    serve(1, 1, 32'h0000_BEEF, 1'b0, w);
    chk("both_lsb_first", w, 1);
    serve(0, 0, 32'h1111_2222, 1'b0, w);
    chk("both_then_ic", w, 0);

    // Starvation: LSB always pending, IC waiting
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3000;
    nl = 0;
    for (int i = 0; i < LIMIT + 1; i++) begin
      if (!lsb_req_valid) new_lsb(1'b0, 32'h100 + i * 4, 3'd4, 32'h0);
      serve(0, 1, $urandom, 1'b0, w);
      if (w && !ic_req_valid) break;
      if (w) nl++;
      else break;
    end
    chk("starve_lsb_grants", nl, LIMIT);
    chk("starve_ic_served", ic_req_valid, 0);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3100;
    serve(0, 0, $urandom, 1'b0, w);
    chk("starve_cnt_cleared", w, 1);
    serve(0, 0, $urandom, 1'b0, w);

    // clear in IDLE blocks the grant for that cycle
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_4000; clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_idle_no_grant", mc_req_valid, 0);
    serve(0, 1, 32'hABCD_0123, 1'b0, w);

    // clear in ISSUE without ready: load is withdrawn
    new_lsb(1'b0, 32'h40, 3'd1, 32'h0);
    expect_grant(w);
    tick;
    chk("clr_issue_granted", mc_req_valid, 1);
    clear = 1'b1; lsb_req_valid = 1'b0;
    tick;
    clear = 1'b0;
    chk("clr_issue_drop", mc_req_valid, 0);
    tick;
    chk("clr_issue_idle", {mc_req_valid, ic_resp_valid, lsb_resp_valid}, 0);

    // clear in ISSUE together with ready: accepted fetch is drained silently
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_5000;
    expect_grant(w);
    tick;
    chk("clr_rdy_granted", mc_req_valid, 1);
    clear = 1'b1; mc_req_ready = 1'b1; ic_req_valid = 1'b0;
    tick;
    clear = 1'b0; mc_req_ready = 1'b0;
    chk("clr_rdy_drop", mc_req_valid, 0);
    mc_resp_valid = 1'b1; mc_resp_data = 32'h5555_AAAA;
    tick;
    mc_resp_valid = 1'b0;
    chk("clr_rdy_no_pulse", {ic_resp_valid, lsb_resp_valid}, 0);

    // clear in WAIT of a fetch: no pulse, no grant until the response is discarded
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_6000;
    expect_grant(w);
    tick;
    chk("clr_wait_granted", mc_req_valid, 1);
    mc_req_ready = 1'b1;
    tick;
    mc_req_ready = 1'b0;
    clear = 1'b1; ic_req_valid = 1'b0;
    new_lsb(1'b0, 32'h60, 3'd4, 32'h0);
    tick;
    clear = 1'b0;
    chk("drain_no_grant_1", mc_req_valid, 0);
    tick;
    chk("drain_no_grant_2", {mc_req_valid, ic_resp_valid, lsb_resp_valid}, 0);
    mc_resp_valid = 1'b1; mc_resp_data = 32'hDEAD_BEEF;
    tick;
    mc_resp_valid = 1'b0;
    chk("drain_discard", {mc_req_valid, ic_resp_valid, lsb_resp_valid}, 0);
    serve(0, 0, 32'h7777_8888, 1'b0, w);
    chk("after_drain_lsb", w, 1);

    // clear in WAIT of a store is ignored
    new_lsb(1'b1, 32'h0003_0004, 3'd4, 32'h1234_5678);
    serve(0, 2, 32'hFFFF_FFFF, 1'b1, w);
    chk("store_clr_owner", w, 1);

    // Asynchronous reset while ISSUE holds mc_req_valid
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_7000;
    tick;
    chk("rst_pre_valid", mc_req_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {mc_req_valid, mc_req_is_write, ic_resp_valid, lsb_resp_valid}, 0);
    chk("rst_async_addr", mc_req_addr, 0);
    chk("rst_async_len", {29'd0, mc_req_len}, 0);
    ic_req_valid = 1'b0;
    tick;
    rst = 1'b0;
    m_starve = 0;
    tick;
    chk("rst_no_resp", {mc_req_valid, ic_resp_valid, lsb_resp_valid}, 0);

    // rdy low in WAIT freezes everything; pulse follows rdy's return
    new_lsb(1'b0, 32'h8000, 3'd4, 32'h0);
    expect_grant(w);
    tick;
    chk("rdy_granted", mc_req_valid, 1);
    mc_req_ready = 1'b1;
    tick;
    mc_req_ready = 1'b0;
    rdy = 1'b0; mc_resp_valid = 1'b1; mc_resp_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rdy_freeze_pulse", {mc_req_valid, ic_resp_valid, lsb_resp_valid}, 0);
      chk("rdy_freeze_addr", mc_req_addr, 32'h8000);
    end
    rdy = 1'b1;
    tick;
    mc_resp_valid = 1'b0;
    chk("rdy_pulse", lsb_resp_valid, 1);
    chk("rdy_data", lsb_resp_data, 32'hCAFE_F00D);
    lsb_req_valid = 1'b0;
    tick;
    chk("rdy_pulse_end", lsb_resp_valid, 0);

    // Random traffic against the arbitration and response model
    for (int t = 0; t < 40; t++) begin
      if (!ic_req_valid && ($urandom % 2 == 0)) begin
        ic_req_valid = 1'b1; ic_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsb_req_valid && (($urandom % 2 == 0) || !ic_req_valid)) begin
        case ($urandom % 3)
          0: rl = 3'd1;
          1: rl = 3'd2;
          default: rl = 3'd4;
        endcase
        new_lsb(1'($urandom % 2), $urandom, rl, $urandom);
      end
      serve(int'($urandom % 3), int'($urandom % 3), $urandom, 1'($urandom % 2), w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares the single byte-serial memory controller between the instruction cache and the load/store buffer. Selects one requester, latches its request, and issues it to the controller with a valid/ready handshake. Routes the one-cycle response back to the owner and drops speculative reads on `clear`. The block sits between InstCache/LSB and the memory controller; the controller itself no longer arbitrates.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, maximum consecutive LSB grants while an IC request is pending

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low freezes all state
clear  in  1  pipeline flush (misprediction)
ic_req_valid  in  1  fetch request; held until response or clear
ic_req_addr  in  ADDR_W  fetch address
ic_resp_valid  out  1  one-cycle fetch-done pulse
ic_resp_data  out  DATA_W  fetched instruction
lsb_req_valid  in  1  load/store request; held until response
lsb_req_is_write  in  1  1=store, 0=load
lsb_req_addr  in  ADDR_W  byte address
lsb_req_len  in  3  bytes: 1, 2 or 4
lsb_req_wdata  in  DATA_W  store data, little-endian
lsb_resp_valid  out  1  one-cycle done pulse (load data or store ack)
lsb_resp_data  out  DATA_W  load data, zero-extended; 0 for stores
mc_req_valid  out  1  request to controller
mc_req_is_write  out  1  latched write flag (0 for fetch)
mc_req_addr  out  ADDR_W  latched address
mc_req_len  out  3  latched length (4 for fetch)
mc_req_wdata  out  DATA_W  latched write data
mc_req_ready  in  1  controller accepts request this cycle
mc_resp_valid  in  1  controller completion pulse
mc_resp_data  in  DATA_W  controller read data

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, owner NONE, starve_cnt 0.
- Registered outputs: every output is registered. When rdy=0, state, counters and all outputs hold. The controller is frozen by the same rdy, so no response is lost.
- Response pulses: `ic_resp_valid` and `lsb_resp_valid` are high for exactly one cycle, then return to 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE arbitration, evaluated each cycle with clear=0:
  - Grant LSB if lsb_req_valid and (starve_cnt < STARVE_LIMIT or !ic_req_valid).
  - Otherwise grant IC if ic_req_valid.
  - On a grant: latch the request fields into the mc_req_* registers, set owner, set mc_req_valid=1, go to ISSUE.
  - For an IC grant, mc_req_is_write=0 and mc_req_len=4.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on an LSB grant while ic_req_valid=1.
  - Reset to 0 on an IC grant, or on an LSB grant with ic_req_valid=0.
- ISSUE: mc_req_valid stays high and the mc_req_* fields stay stable until mc_req_ready=1 is sampled. Then mc_req_valid drops to 0 the next cycle and the state goes to WAIT.
- WAIT: on mc_resp_valid=1:
  - Drive the owner's resp_valid=1 next cycle, with mc_resp_data on the owner's resp_data.
  - For a store, lsb_resp_data=0.
  - Go to IDLE.
  - A new grant is evaluated in IDLE no earlier than the cycle after the response pulse. This avoids re-granting a requester whose valid is still high.
- Minimum latency: request seen in IDLE at cycle N. mc_req_valid is high at N+1. If ready at N+1 and the controller responds at N+1+k, the owner's pulse is at N+2+k.
- clear:
  - Cancels IC fetches and LSB loads. Never cancels a store.
  - In IDLE: no grant that cycle.
  - In ISSUE, cancellable owner, ready=0 that cycle: drop mc_req_valid, go to IDLE.
  - In ISSUE, cancellable owner, ready=1 the same cycle: the request is already accepted; go to DRAIN.
  - In WAIT, cancellable owner: go to DRAIN. If mc_resp_valid=1 in the same cycle, discard the response and go directly to IDLE.
  - Store owner: clear is ignored and the store completes normally with lsb_resp_valid.
- DRAIN: wait for mc_resp_valid, discard the data with no resp pulse, then go to IDLE. clear during DRAIN has no further effect.
- Reset mid-operation: returns immediately to the reset values; no response is generated.
- Out-of-protocol input: mc_resp_valid outside WAIT/DRAIN is ignored.

Test Plan:
- IC only, addr 0x0000_1000, ready at the first ISSUE cycle, response 0x00A00093 three cycles later -> mc_req_addr=0x1000, len=4, is_write=0; ic_resp_valid one cycle with data 0x00A00093; lsb_resp_valid stays 0.
- IC and LSB load (addr 0x20, len 2) valid in the same cycle -> LSB granted first; mc_req_len=2; response 0x0000BEEF goes to lsb_resp_data; IC granted at the next arbitration.
- LSB continuously valid with IC pending, STARVE_LIMIT=4 -> exactly 4 LSB grants, then 1 IC grant, then starve_cnt=0.
- clear during WAIT of an IC fetch, response 2 cycles later -> state DRAIN; no ic_resp_valid; the next grant happens only after the discarded response.
- clear during WAIT of a 4-byte store of 0x12345678 to 0x30004 -> clear ignored; mc_req_wdata=0x12345678; lsb_resp_valid=1 with data 0 on completion.
- rst asserted in ISSUE with mc_req_valid=1 -> all outputs 0 asynchronously; rdy=0 for 3 cycles in WAIT -> state and outputs unchanged, pulse delivered after rdy returns.
